mbus_int_ctrl_multi: RTL

Multi-channel MBus interrupt front end that replaces the single-request interrupt controller on member layers with several independent interrupt sources. It captures rising edges on `N_CH` request lines and holds them as per-channel pending bits. It arbitrates among pending channels and raises either a bus-level or a wire-level external interrupt once the bus is not busy. It also adds an acknowledge timeout with drop reporting. It sits between layer-controller interrupt sources and the MBus member-layer wire/bus logic.

---
 rtl/mbus_int_pkg.sv | 12 +
 rtl/mbus_int_arbiter.sv | 42 ++++
 rtl/mbus_int_ctrl_multi.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mbus_int_pkg.sv
// Shared types for the multi-channel MBus interrupt front end.
package mbus_int_pkg;
  typedef enum logic [1:0] {
    IDLE,
    ARB,
    WAIT_BUS,
    ASSERT
  } state_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;
endpackage

// File: rtl/mbus_int_arbiter.sv
// Grant selection over pending channels: fixed priority (lowest index) or
// round-robin starting from a pointer that moves past each finished channel.
module mbus_int_arbiter
  import mbus_int_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int ARB_MODE = ARB_FIXED,
  parameter int CH_W     = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] req,
  input  logic            advance,
  input  logic [CH_W-1:0] done_ch,
  output logic [CH_W-1:0] grant,
  output logic            grant_valid
);
  localparam int unsigned N_U = N_CH;

  logic [CH_W-1:0] ptr;

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    for (int unsigned off = 0; off < N_U; off++) begin
      int unsigned idx;
      idx = (ARB_MODE == ARB_RR) ? (32'(ptr) + off) % N_U : off;
      if (!grant_valid && req[idx]) begin
        grant       = CH_W'(idx);
        grant_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (done_ch == CH_W'(N_CH - 1)) ? '0 : done_ch + CH_W'(1);
    end
  end
endmodule

// File: rtl/mbus_int_ctrl_multi.sv
// Multi-channel interrupt front end: edge capture into pending bits,
// arbitration, bus-busy gating and acknowledge timeout with drop pulse.
module mbus_int_ctrl_multi
  import mbus_int_pkg::*;
#(
  parameter  int N_CH     = 4,
  parameter  int ARB_MODE = ARB_FIXED,
  parameter  int TIMEOUT  = 1023,
  localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            CLKIN,
  input  logic            RESET,
  input  logic            BC_RELEASE_ISO,
  input  logic            SC_CLR_BUSY,
  input  logic            MBUS_CLR_BUSY,
  input  logic [N_CH-1:0] REQ_INT,
  input  logic [N_CH-1:0] INT_MASK,
  input  logic            BC_PWR_ON,
  input  logic            LC_PWR_ON,
  input  logic            CLR_EXT_INT,
  output logic            EXTERNAL_INT_TO_WIRE,
  output logic            EXTERNAL_INT_TO_BUS,
  output logic [CH_W-1:0] INT_CH_ID,
  output logic [N_CH-1:0] INT_PENDING,
  output logic            INT_DROPPED
);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TERM = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  state_t          state, next_state;
  logic            busy;
  logic            armed;
  logic [N_CH-1:0] req_q, pending, edges, clr_vec;
  logic [TW-1:0]   cnt;
  logic            ack, drop, bus_d, wire_d;
  logic [CH_W-1:0] grant;
  logic            grant_valid;

  // Edges are ignored on the first cycle after reset so a level already held
  // high through reset is absorbed into req_q instead of raising a request.
  assign edges       = armed ? (REQ_INT & ~req_q & INT_MASK) : '0;
  assign clr_vec     = (ack || drop) ? (N_CH'(1) << INT_CH_ID) : '0;
  assign INT_PENDING = pending;

  mbus_int_arbiter #(
    .N_CH    (N_CH),
    .ARB_MODE(ARB_MODE),
    .CH_W    (CH_W)
  ) u_arb (
    .clk        (CLKIN),
    .rst        (RESET),
    .req        (pending & INT_MASK),
    .advance    (ack || drop),
    .done_ch    (INT_CH_ID),
    .grant      (grant),
    .grant_valid(grant_valid)
  );

  always_ff @(posedge CLKIN or posedge RESET) begin
    if (RESET) begin
      busy    <= 1'b0;
      armed   <= 1'b0;
      req_q   <= '0;
      pending <= '0;
    end else begin
      if (SC_CLR_BUSY || MBUS_CLR_BUSY) busy <= 1'b0;
      else if (BC_RELEASE_ISO)          busy <= 1'b1;
      armed   <= 1'b1;
      req_q   <= REQ_INT;
      pending <= (pending & ~clr_vec) | edges;
    end
  end

  always_ff @(posedge CLKIN or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      if (state != ASSERT) cnt <= '0;
      else if (cnt != '1)  cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    ack        = 1'b0;
    drop       = 1'b0;
    case (state)
      IDLE:     if (|(pending & INT_MASK)) next_state = ARB;
      ARB:      next_state = grant_valid ? WAIT_BUS : IDLE;
      WAIT_BUS: if (!busy) next_state = ASSERT;
      ASSERT: begin
        if (CLR_EXT_INT) begin
          ack        = 1'b1;
          next_state = IDLE;
        end else if (TIMEOUT != 0 && cnt == TERM) begin
          drop       = 1'b1;
          next_state = IDLE;
        end
      end
      default:  next_state = IDLE;
    endcase
  end

  // Mode is chosen on ASSERT entry and held until exit.
  always_comb begin
    bus_d  = 1'b0;
    wire_d = 1'b0;
    if (next_state == ASSERT) begin
      if (state == ASSERT) begin
        bus_d  = EXTERNAL_INT_TO_BUS;
        wire_d = EXTERNAL_INT_TO_WIRE;
      end else if (BC_PWR_ON && LC_PWR_ON) begin
        bus_d  = 1'b1;
      end else begin
        wire_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLKIN or posedge RESET) begin
    if (RESET) begin
      EXTERNAL_INT_TO_BUS  <= 1'b0;
      EXTERNAL_INT_TO_WIRE <= 1'b0;
      INT_DROPPED          <= 1'b0;
      INT_CH_ID            <= '0;
    end else begin
      EXTERNAL_INT_TO_BUS  <= bus_d;
      EXTERNAL_INT_TO_WIRE <= wire_d;
      INT_DROPPED          <= drop;
      if (state == ARB) INT_CH_ID <= grant;
    end
  end
endmodule
